mem_stall_responder: RTL and testbench
======================================

Name: mem_stall_responder

Overview:
- Multi-cycle data-memory responder: the device side of the memory-stage request interface (enable/wr/addr/write-data in, read-data out).
- Replaces the single-cycle ideal data memory with a fixed-latency model.
- Raises stall while a request is in flight and pulses done when the access completes, so the pipeline's stall/hazard logic can be exercised.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 16-bit words in the backing array.
- LATENCY, 3, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  request valid; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; qualified by enable.
- addr  input  16  byte address; must be even.
- data_in  input  16  write data.
- data_out  output  16  read data, registered.
- done  output  1  one-cycle completion pulse, registered.
- stall  output  1  pipeline hold request, combinational.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  misalignment flag; valid only with done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, data_out=0, done=0, err=0.
  - Reset does not clear the backing array.
  - Reset mid-request aborts the request: no write is committed, and no done is issued.
- States: IDLE, BUSY, DONE.
- Word index = addr[DEPTH_LOG2:1]. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- Acceptance: cycle T0 in which state=IDLE and enable=1. On the T0 edge, addr, data_in and wr are latched. The requester need not hold its inputs after T0.
- Aligned request (addr[0]=0):
  - LATENCY=1: IDLE -> DONE.
  - Otherwise: IDLE -> BUSY with counter=LATENCY-2. BUSY decrements the counter each cycle, and goes to DONE on the edge after counter=0.
  - Result: done=1 in exactly cycle T0+LATENCY.
- Misaligned request (addr[0]=1):
  - IDLE -> DONE directly, with err=1, done=1 in T0+1.
  - No array access; data_out is held.
- Array access is committed on the edge entering DONE:
  - Read: data_out <= array[index].
  - Write: array[index] <= data_in; data_out is held.
- DONE lasts exactly one cycle, then returns to IDLE. enable is ignored in DONE and BUSY.
- Throughput: the next request can be accepted at T0+LATENCY+1 at the earliest (back-to-back spacing LATENCY+1 cycles).
- Output timing:
  - data_out holds its last value until the next read completion.
  - err is 0 except in a misaligned DONE cycle.
  - stall = (state==IDLE & enable) | (state==BUSY). It is high from T0 through T0+LATENCY-1 and low in the done cycle. For a misaligned request it is high only in T0.
  - busy = (state != IDLE).
- Write then read to the same word returns the new value; there are no bypass or ordering hazards, because only one request is ever outstanding.
- wr while enable=0 has no effect.

Test Plan:
- Reset: rst=0 mid-BUSY (write to 0x0010 of 0xBEEF in flight) -> outputs 0 immediately; after release, a read of 0x0010 returns the prior content, not 0xBEEF.
- Write/read, LATENCY=3: write 0xA5A5 to 0x0020 at T0 -> stall=1 at T0..T2, done=1 at T3 only; read 0x0020 accepted at T4 -> done at T7, data_out=0xA5A5, held afterward.
- Misaligned: read 0x0021 at T0 -> stall=1 at T0 only; err=1 and done=1 at T1; data_out unchanged; array unchanged.
- Ignored requests: enable held high through BUSY/DONE with a changing addr -> only the T0 request executes; a second acceptance occurs at T4 with the addr presented then.
- Aliasing, DEPTH_LOG2=10: write 0x1234 to 0x0002, then read 0x0802 -> data_out=0x1234.
- LATENCY=1 build: read at T0 -> stall=1 at T0, done=1 at T1; back-to-back reads at T0 and T2 both complete correctly.

Source files
------------

// File: rtl/mem_stall_responder_if.sv
// Memory-stage request bus between the pipeline (master) and a data-memory responder (slave).
// The requester drives the request fields; the responder returns data, completion and hold signals.
interface mem_stall_responder_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] dataIn;
   logic [15:0] dataOut;
   logic        done;
   logic        stall;
   logic        busy;
   logic        err;

   modport master (
      output enable, wr, addr, dataIn,
      input  dataOut, done, stall, busy, err
   );

   modport slave (
      input  enable, wr, addr, dataIn,
      output dataOut, done, stall, busy, err
   );
endinterface

// File: rtl/mem_stall_responder.sv
// Fixed-latency data memory that stalls the pipeline while one request is in flight
// and pulses done (with err for odd addresses) when the access completes.
module mem_stall_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input logic clk,
   input logic rst,
   mem_stall_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } stateT;

   localparam int Words = 1 << DEPTH_LOG2;
   localparam logic [3:0] LoadCount = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

   stateT                 state;
   stateT                 nextState;
   logic [3:0]            counter;
   logic [3:0]            nextCounter;
   logic [DEPTH_LOG2-1:0] idxQ;
   logic                  wrQ;
   logic [15:0]           dataQ;
   logic [15:0]           dataOutQ;
   logic                  doneQ;
   logic                  errQ;
   logic [15:0]           mem [Words];

   logic                  accept;
   logic                  enterDone;
   logic                  accWr;
   logic                  accMis;
   logic [DEPTH_LOG2-1:0] accIdx;
   logic [15:0]           accData;
   logic                  unusedAddrBits;

   assign accept         = (state == IDLE) && bus.enable;
   assign unusedAddrBits = ^bus.addr[15:DEPTH_LOG2+1];

   // Next-state and latency counter; misaligned or single-cycle requests skip BUSY.
   always_comb begin
      nextState   = state;
      nextCounter = counter;
      case (state)
         IDLE: begin
            if (bus.enable) begin
               if (bus.addr[0] || (LATENCY == 1)) begin
                  nextState = DONE;
               end else begin
                  nextState   = BUSY;
                  nextCounter = LoadCount;
               end
            end
         end
         BUSY: begin
            if (counter == 4'd0) begin
               nextState = DONE;
            end else begin
               nextCounter = counter - 4'd1;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // The access fields come straight from the bus when DONE is entered from IDLE,
   // otherwise from the copy latched at acceptance (which is always aligned).
   always_comb begin
      enterDone = (nextState == DONE) && (state != DONE);
      accWr     = wrQ;
      accMis    = 1'b0;
      accIdx    = idxQ;
      accData   = dataQ;
      if (state == IDLE) begin
         accWr   = bus.wr;
         accMis  = bus.addr[0];
         accIdx  = bus.addr[DEPTH_LOG2:1];
         accData = bus.dataIn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         counter  <= 4'd0;
         idxQ     <= '0;
         wrQ      <= 1'b0;
         dataQ    <= 16'd0;
         dataOutQ <= 16'd0;
         doneQ    <= 1'b0;
         errQ     <= 1'b0;
      end else begin
         state   <= nextState;
         counter <= nextCounter;
         doneQ   <= enterDone;
         errQ    <= enterDone && accMis;
         if (accept) begin
            idxQ  <= bus.addr[DEPTH_LOG2:1];
            wrQ   <= bus.wr;
            dataQ <= bus.dataIn;
         end
         if (enterDone && !accMis && !accWr) begin
            dataOutQ <= mem[accIdx];
         end
      end
   end

   // The array has no reset; a request aborted by reset must never commit its write.
   always_ff @(posedge clk) begin
      if (rst && enterDone && !accMis && accWr) begin
         mem[accIdx] <= accData;
      end
   end

   assign bus.stall   = accept || (state == BUSY);
   assign bus.busy    = (state != IDLE);
   assign bus.dataOut = dataOutQ;
   assign bus.done    = doneQ;
   assign bus.err     = errQ;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Randomized bench for mem_stall_responder against a transaction-level memory model;
// a second LATENCY=1 instance covers the single-cycle build.
module tb_mem_stall_responder;

   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mem_stall_responder_if bus ();
   mem_stall_responder_if bus1 ();

   mem_stall_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   mem_stall_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] refMem  [0:1023];
   logic [15:0] refMem1 [0:1023];
   logic [15:0] expOut  = 16'd0;
   logic [15:0] expOut1 = 16'd0;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int wordIndex(input logic [15:0] a);
      return (int'(a) % 2048) / 2;
   endfunction

   // One request on the LATENCY=3 instance; optionally keeps enable high with junk while it is in flight.
   task automatic applyStimulus(input logic isWr, input logic [15:0] a, input logic [15:0] d, input bit holdEnable);
      int lat;
      bit mis;
      mis = a[0];
      lat = mis ? 1 : LAT;
      bus.enable = 1'b1;
      bus.wr     = isWr;
      bus.addr   = a;
      bus.dataIn = d;
      @(negedge clk);
      checkOutput("stallAtAccept", bus.stall, 1'b1);
      checkOutput("busyAtAccept", bus.busy, 1'b0);
      checkOutput("doneAtAccept", bus.done, 1'b0);
      if (!mis) begin
         if (isWr) refMem[wordIndex(a)] = d;
         else      expOut = refMem[wordIndex(a)];
      end
      @(posedge clk); #1;
      bus.enable = holdEnable;
      bus.wr     = 1'($urandom);
      bus.addr   = 16'($urandom);
      bus.dataIn = 16'($urandom);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         checkOutput("done", bus.done, (k == lat));
         checkOutput("stall", bus.stall, (k < lat));
         checkOutput("busy", bus.busy, 1'b1);
         if (k == lat) begin
            checkOutput("err", bus.err, mis);
            checkOutput("dataOut", bus.dataOut, expOut);
         end
         @(posedge clk); #1;
         if (holdEnable) begin
            bus.wr   = 1'($urandom);
            bus.addr = 16'($urandom);
         end
      end
      bus.enable = 1'b0;
   endtask

   // Idle cycle with a stray wr; nothing may start and outputs must hold.
   task automatic idleCycle();
      bus.enable = 1'b0;
      bus.wr     = 1'b1;
      bus.addr   = 16'($urandom);
      @(negedge clk);
      checkOutput("idleStall", bus.stall, 1'b0);
      checkOutput("idleBusy", bus.busy, 1'b0);
      checkOutput("idleDone", bus.done, 1'b0);
      checkOutput("idleErr", bus.err, 1'b0);
      checkOutput("idleData", bus.dataOut, expOut);
      @(posedge clk); #1;
   endtask

   task automatic requestL1(input logic isWr, input logic [15:0] a, input logic [15:0] d);
      bus1.enable = 1'b1;
      bus1.wr     = isWr;
      bus1.addr   = a;
      bus1.dataIn = d;
      @(negedge clk);
      checkOutput("l1Stall", bus1.stall, 1'b1);
      checkOutput("l1DoneEarly", bus1.done, 1'b0);
      if (isWr) refMem1[wordIndex(a)] = d;
      else      expOut1 = refMem1[wordIndex(a)];
      @(posedge clk); #1;
      bus1.enable = 1'b0;
      @(negedge clk);
      checkOutput("l1Done", bus1.done, 1'b1);
      checkOutput("l1StallDone", bus1.stall, 1'b0);
      checkOutput("l1Data", bus1.dataOut, expOut1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] a;
      bus.enable  = 1'b0; bus.wr  = 1'b0; bus.addr  = 16'd0; bus.dataIn  = 16'd0;
      bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = 16'd0; bus1.dataIn = 16'd0;
      #12;
      checkOutput("resetData", bus.dataOut, 16'd0);
      checkOutput("resetDone", bus.done, 1'b0);
      checkOutput("resetErr", bus.err, 1'b0);
      checkOutput("resetBusy", bus.busy, 1'b0);
      checkOutput("resetData1", bus1.dataOut, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      requestL1(1'b1, 16'h0004, 16'h5A5A);
      requestL1(1'b1, 16'h0006, 16'h1111);
      requestL1(1'b0, 16'h0004, 16'h0000);
      requestL1(1'b0, 16'h0006, 16'h0000);

      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 16'(i * 2), 16'($urandom), 1'b0);
      idleCycle();

      applyStimulus(1'b1, 16'h0020, 16'hA5A5, 1'b0);
      applyStimulus(1'b0, 16'h0020, 16'h0000, 1'b0);
      idleCycle();
      idleCycle();
      checkOutput("readBackA5A5", bus.dataOut, 16'hA5A5);

      applyStimulus(1'b0, 16'h0021, 16'h0000, 1'b0);
      idleCycle();

      applyStimulus(1'b0, 16'h0030, 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0012, 16'h0000, 1'b1);
      idleCycle();

      applyStimulus(1'b1, 16'h0002, 16'h1234, 1'b0);
      applyStimulus(1'b0, 16'h0802, 16'h0000, 1'b0);
      checkOutput("aliasRead", bus.dataOut, 16'h1234);

      // Abort a write mid-flight; the old word must survive.
      bus.enable = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0010; bus.dataIn = 16'hBEEF;
      @(posedge clk); #1;
      bus.enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("abortData", bus.dataOut, 16'd0);
      checkOutput("abortDone", bus.done, 1'b0);
      checkOutput("abortBusy", bus.busy, 1'b0);
      checkOutput("abortStall", bus.stall, 1'b0);
      expOut = 16'd0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      idleCycle();
      applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b0);

      for (int i = 0; i < 200; i++) begin
         a = 16'({$urandom_range(0, 31), 4'b0000, 6'($urandom_range(0, 63)), 1'b0});
         if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
         applyStimulus(1'($urandom), a, 16'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idleCycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
